patgen: RTL
===========

PATGEN -- requirements
Module: patgen

Interface
REQ-001 Parameter DW, default 8, data/step/limit width in bits (legal 4..32).
REQ-002 Parameter POLY, default 8'hB8, Galois LFSR feedback mask (DW bits).
REQ-003 Parameter SEED, default 1, LFSR start value (DW bits).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_h  input  1  reset, asynchronous, active-high.
REQ-006 ena  input  1  run enable; low forces IDLE.
REQ-007 mode  input  2  pattern select: 00 increment, 01 decrement, 10 LFSR, 11 constant.
REQ-008 step  input  DW  increment/decrement amount.
REQ-009 lim  input  DW  upper bound (inc/dec) or word count minus 1 (LFSR/constant).
REQ-010 rdy  input  1  consumer ready.
REQ-011 vld  output  1  data valid.
REQ-012 data  output  DW  pattern word, registered.
REQ-013 stop  output  1  sequence complete.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE: vld=0, data=0, stop=0; ena=1 -> RUN next cycle, with mode/step/lim captured into shadow registers on that edge.
REQ-016 Input changes to mode/step/lim during RUN/DONE SHALL be ignored.
REQ-017 RUN entry word: 0 (inc), lim (dec), SEED (LFSR; if SEED=0, 1 is used), SEED (constant); vld=1 from the first RUN cycle.
REQ-018 A transfer SHALL occur only when vld=1 and rdy=1; data SHALL advance exactly once per transfer and hold while rdy=0.
REQ-019 Increment: next = data + step, computed DW+1 bits wide; the current word is last when data+step > lim; no wrap.
REQ-020 Decrement: next = data - step; the current word is last when data < step; no underflow.
REQ-021 LFSR: next = lsb ? (data>>1)^POLY : data>>1; constant: data held; both are last when the internal word counter equals lim.
REQ-022 step=0 in inc/dec SHALL count words like LFSR/constant (lim+1 words), so the sequence never hangs.
REQ-023 On transfer of the last word: RUN -> DONE, vld=0, stop=1 on the following cycle.
REQ-024 DONE: stop held 1, data holds last word, until ena=0.
REQ-025 ena=0 in any state SHALL give IDLE next cycle (vld=0, stop=0, data=0, counter=0), including mid-transfer.
REQ-026 Internal word counter SHALL be DW bits, clear in IDLE, and increment per transfer.

Reset
REQ-027 rst_h=1 SHALL immediately force IDLE, vld=0, stop=0, data=0, counter=0 and shadow registers=0, independent of clk.
REQ-028 After rst_h release, the first RUN entry SHALL require ena sampled high on a clk edge.

Configuration
REQ-029 Macro PATGEN_WRAP_EN defined: on last-word transfer the FSM SHALL stay in RUN, reload the entry word next cycle, clear the counter and pulse stop for exactly one cycle with vld kept 1.
REQ-030 PATGEN_WRAP_EN undefined: behaviour per REQ-023/REQ-024; no DONE-to-RUN path exists other than through IDLE.

Verification
REQ-031 DW=8, mode=00, step=1, lim=255, rdy=1 -> 256 words 0..255 on consecutive cycles, then stop=1, vld=0.
REQ-032 mode=00, step=3, lim=10 -> words 0,3,6,9, then stop; mode=01, step=4, lim=10 -> 10,6,2, then stop.
REQ-033 mode=10, SEED=1, POLY=8'hB8, lim=3 -> 01,B8,5C,2E, then stop.
REQ-034 mode=00, step=1, rdy toggled 1,0,0,1 -> each word held while rdy=0, no word skipped or repeated.
REQ-035 rst_h pulsed mid-RUN between clk edges -> vld/data/stop 0 without a clock edge; ena=0 mid-RUN -> IDLE next cycle.
REQ-036 PATGEN_WRAP_EN defined, step=1, lim=2 -> 0,1,2,0,1,2..., with a 1-cycle stop pulse after each 2.

Source files
------------

// File: rtl/patgen.sv
// Pattern generator: streams increment, decrement, Galois LFSR or constant
// words under valid/ready handshaking, then flags completion with stop.
// Optional feature macro PATGEN_WRAP_EN: when defined, the sequence restarts
// from its entry word after the last transfer and stop pulses for one cycle
// instead of parking in DONE.
module patgen #(
  parameter int             DW   = 8,
  parameter logic [DW-1:0]  POLY = 'hB8,
  parameter logic [DW-1:0]  SEED = 'd1
) (
  input  logic          clk,
  input  logic          rst_h,
  input  logic          ena,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] step,
  input  logic [DW-1:0] lim,
  input  logic          rdy,
  output logic          vld,
  output logic [DW-1:0] data,
  output logic          stop
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1
  localparam logic [DW-1:0] LFSR_SEED = (SEED == '0) ? {{(DW-1){1'b0}}, 1'b1} : SEED;

  state_t        r_state;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_cnt;
  logic          r_stop;
  logic [1:0]    r_mode;
  logic [DW-1:0] r_step;
  logic [DW-1:0] r_lim;

  state_t        w_nextState;
  logic [DW-1:0] w_nextData;
  logic [DW-1:0] w_nextCnt;
  logic          w_nextStop;
  logic          w_capture;
  logic          w_xfer;
  logic          w_last;
  logic          w_cntLast;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_advance;

  function automatic logic [DW-1:0] entryWord(input logic [1:0] m, input logic [DW-1:0] l);
    logic [DW-1:0] w;
    case (m)
      2'b00:   w = '0;
      2'b01:   w = l;
      2'b10:   w = LFSR_SEED;
      default: w = SEED;
    endcase
    return w;
  endfunction

  assign w_xfer    = (r_state == RUN) && rdy;
  assign w_sum     = {1'b0, r_data} + {1'b0, r_step};
  assign w_cntLast = (r_cnt == r_lim);

  // Decide whether the word currently on data is the final one; a zero step
  // falls back to word counting so the sequence cannot stall forever
  always_comb begin
    w_last = w_cntLast;
    case (r_mode)
      2'b00:   w_last = (r_step == '0) ? w_cntLast : (w_sum > {1'b0, r_lim});
      2'b01:   w_last = (r_step == '0) ? w_cntLast : (r_data < r_step);
      default: w_last = w_cntLast;
    endcase
  end

  // Compute the word that follows the current one for the captured mode
  always_comb begin
    w_advance = r_data;
    case (r_mode)
      2'b00:   w_advance = w_sum[DW-1:0];
      2'b01:   w_advance = r_data - r_step;
      2'b10:   w_advance = r_data[0] ? ((r_data >> 1) ^ POLY) : (r_data >> 1);
      default: w_advance = r_data;
    endcase
  end

  // Next-state and next-datapath values; dropping ena overrides everything
  always_comb begin
    w_nextState = r_state;
    w_nextData  = r_data;
    w_nextCnt   = r_cnt;
    w_nextStop  = r_stop;
    w_capture   = 1'b0;
    if (!ena) begin
      w_nextState = IDLE;
      w_nextData  = '0;
      w_nextCnt   = '0;
      w_nextStop  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nextState = RUN;
          w_capture   = 1'b1;
          w_nextData  = entryWord(mode, lim);
          w_nextCnt   = '0;
          w_nextStop  = 1'b0;
        end
        RUN: begin
          w_nextStop = 1'b0;
          if (w_xfer) begin
            if (w_last) begin
`ifdef PATGEN_WRAP_EN
              w_nextData = entryWord(r_mode, r_lim);
              w_nextCnt  = '0;
              w_nextStop = 1'b1;
`else
              w_nextState = DONE;
              w_nextStop  = 1'b1;
`endif
            end else begin
              w_nextData = w_advance;
              w_nextCnt  = r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          w_nextStop = 1'b1;
        end
        default: begin
          w_nextState = IDLE;
          w_nextData  = '0;
          w_nextCnt   = '0;
          w_nextStop  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_data  <= w_nextData;
      r_cnt   <= w_nextCnt;
      r_stop  <= w_nextStop;
    end
  end

  // Shadow copies of mode/step/lim, frozen while the sequence runs
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      r_mode <= '0;
      r_step <= '0;
      r_lim  <= '0;
    end else if (w_capture) begin
      r_mode <= mode;
      r_step <= step;
      r_lim  <= lim;
    end
  end

  assign vld  = (r_state == RUN);
  assign data = r_data;
  assign stop = r_stop;

endmodule
